// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator producing W keystream bits per clock.
// A start/busy command interface loads key/IV and runs the warm-up steps,
// then words are emitted on a valid/ready stream.
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous active-high reset
//   i_start     begin a run (sampled only in IDLE)
//   i_key       80-bit key, sampled on accepted start
//   i_iv        80-bit IV, sampled on accepted start
//   i_len       number of W-bit words to emit, sampled on accepted start
//   o_busy      high during warm-up and streaming
//   o_ks_data   keystream word, bit i = output of step i of the word
//   o_ks_valid  o_ks_data holds a valid word
//   i_ks_ready  consumer accepts word when valid && ready
//   o_done      one-cycle pulse after the run completes
module trivium_keystream_gen #(
    parameter int unsigned W      = 8,
    parameter int unsigned WARMUP = 1152,
    parameter int unsigned LEN_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [79:0]      i_key,
    input  logic [79:0]      i_iv,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic [W-1:0]     o_ks_data,
    output logic             o_ks_valid,
    input  logic             i_ks_ready,
    output logic             o_done
);

    localparam int unsigned WARM_CYC = WARMUP / W;
    localparam int unsigned CNT_W    = $clog2(WARM_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WARM,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [287:0]       r_s;
    logic [LEN_W-1:0]   r_words_left;
    logic [CNT_W-1:0]   r_step_cnt;
    logic               r_busy;
    logic               r_valid;
    logic               r_done;

    logic [287:0]       w_adv_s;
    logic [W-1:0]       w_z;
    logic               w_t1;
    logic               w_t2;
    logic               w_t3;

    // W chained Trivium steps from the registered state; z bits form the word
    always_comb begin
        w_adv_s = r_s;
        w_z     = '0;
        w_t1    = 1'b0;
        w_t2    = 1'b0;
        w_t3    = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            w_t1   = w_adv_s[65] ^ w_adv_s[92];
            w_t2   = w_adv_s[161] ^ w_adv_s[176];
            w_t3   = w_adv_s[242] ^ w_adv_s[287];
            w_z[i] = w_t1 ^ w_t2 ^ w_t3;
            w_t1   = w_t1 ^ (w_adv_s[90] & w_adv_s[91]) ^ w_adv_s[170];
            w_t2   = w_t2 ^ (w_adv_s[174] & w_adv_s[175]) ^ w_adv_s[263];
            w_t3   = w_t3 ^ (w_adv_s[285] & w_adv_s[286]) ^ w_adv_s[68];
            w_adv_s = {w_adv_s[286:177], w_t2,
                       w_adv_s[175:93],  w_t1,
                       w_adv_s[91:0],    w_t3};
        end
    end

    // Control FSM and cipher state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_s          <= '0;
            r_words_left <= '0;
            r_step_cnt   <= '0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_s          <= {3'b111, 112'b0, i_iv, 13'b0, i_key};
                        r_words_left <= i_len;
                        r_step_cnt   <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_WARM;
                    end
                end
                ST_WARM: begin
                    r_s <= w_adv_s;
                    if (r_step_cnt == CNT_W'(WARM_CYC - 1)) begin
                        r_step_cnt <= '0;
                        if (r_words_left != '0) begin
                            r_valid <= 1'b1;
                            r_state <= ST_STREAM;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + CNT_W'(1);
                    end
                end
                ST_STREAM: begin
                    // Stall keeps r_s, so o_ks_data stays stable
                    if (i_ks_ready) begin
                        r_s          <= w_adv_s;
                        r_words_left <= r_words_left - LEN_W'(1);
                        if (r_words_left == LEN_W'(1)) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_ks_valid = r_valid;
    assign o_done     = r_done;
    assign o_ks_data  = w_z;

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Testbench for trivium_keystream_gen: three instances (W=1, W=8, W=8 with 4-bit
// length) checked against a serial Trivium model through an expected-word queue.
module tb_trivium_keystream_gen;

    localparam int WARMUP = 1152;

    typedef struct {
        int          sel;
        logic [79:0] key;
        logic [79:0] iv;
        int          len;
        int          pct;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [79:0] key;
    logic [79:0] iv;
    logic [15:0] len;
    logic        ready;
    int          sel;

    logic        busy1, valid1, done1;
    logic [0:0]  data1;
    logic        busy8, valid8, done8;
    logic [7:0]  data8;
    logic        busys, valids, dones;
    logic [7:0]  datas;

    logic        obs_busy, obs_valid, obs_done;
    logic [7:0]  obs_data;

    logic [7:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[6];

    always #5 clk = ~clk;

    trivium_keystream_gen #(.W(1), .WARMUP(WARMUP), .LEN_W(16)) u_w1 (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[0]), .i_key(key), .i_iv(iv),
        .i_len(len), .o_busy(busy1), .o_ks_data(data1), .o_ks_valid(valid1),
        .i_ks_ready(ready), .o_done(done1));

    trivium_keystream_gen #(.W(8), .WARMUP(WARMUP), .LEN_W(16)) u_w8 (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[1]), .i_key(key), .i_iv(iv),
        .i_len(len), .o_busy(busy8), .o_ks_data(data8), .o_ks_valid(valid8),
        .i_ks_ready(ready), .o_done(done8));

    trivium_keystream_gen #(.W(8), .WARMUP(WARMUP), .LEN_W(4)) u_w8s (
        .i_clk(clk), .i_reset(reset), .i_start(start_v[2]), .i_key(key), .i_iv(iv),
        .i_len(len[3:0]), .o_busy(busys), .o_ks_data(datas), .o_ks_valid(valids),
        .i_ks_ready(ready), .o_done(dones));

    always_comb begin
        case (sel)
            0: begin
                obs_busy = busy1; obs_valid = valid1; obs_done = done1;
                obs_data = {7'b0, data1};
            end
            1: begin
                obs_busy = busy8; obs_valid = valid8; obs_done = done8;
                obs_data = data8;
            end
            default: begin
                obs_busy = busys; obs_valid = valids; obs_done = dones;
                obs_data = datas;
            end
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serial reference model in 1-based Trivium register notation
    task automatic model_push(input logic [79:0] k, input logic [79:0] v,
                              input int l, input int w);
        logic [288:1] m;
        logic         t1, t2, t3, z;
        logic [7:0]   word;
        int           idx;
        m = '0;
        word = '0;
        for (int i = 0; i < 80; i++) begin
            m[i+1]  = k[i];
            m[94+i] = v[i];
        end
        m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
        for (int n = 0; n < WARMUP + l * w; n++) begin
            t1 = m[66] ^ m[93];
            t2 = m[162] ^ m[177];
            t3 = m[243] ^ m[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (m[91] & m[92]) ^ m[171];
            t2 = t2 ^ (m[175] & m[176]) ^ m[264];
            t3 = t3 ^ (m[286] & m[287]) ^ m[69];
            for (int i = 93; i >= 2; i--) m[i] = m[i-1];
            m[1] = t3;
            for (int i = 177; i >= 95; i--) m[i] = m[i-1];
            m[94] = t1;
            for (int i = 288; i >= 179; i--) m[i] = m[i-1];
            m[178] = t2;
            if (n >= WARMUP) begin
                idx = n - WARMUP;
                if (idx % w == 0) word = '0;
                word[idx % w] = z;
                if (idx % w == w - 1) exp_q.push_back(word);
            end
        end
    endtask

    task automatic start_run(input logic [79:0] k, input logic [79:0] v, input int l);
        @(negedge clk);
        key = k;
        iv  = v;
        len = 16'(l);
        start_v[sel] = 1'b1;
        model_push(k, v, l, (sel == 0) ? 1 : 8);
    endtask

    task automatic pop_cmp(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s actual=%0h expected=<none, queue empty>", name, obs_data);
        end else begin
            e = exp_q.pop_front();
            chk(name, 64'(obs_data), 64'(e));
        end
    endtask

    // Watch one run to its done pulse, driving ready and checking words and timing
    task automatic monitor(input int l, input int pct, input int exp_lat, input bit hold);
        int  cyc   = 0;
        int  first = -1;
        int  vcnt  = 0;
        bit  stall = 1'b0;
        bit  fin   = 1'b0;
        logic [7:0] pd = '0;
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (!hold) start_v = '0;
            if (stall) begin
                chk("stall_data", 64'(obs_data), 64'(pd));
                chk("stall_valid", 64'(obs_valid), 64'd1);
            end
            if (obs_valid && first < 0) begin
                first = cyc;
                chk("first_valid_latency", 64'(cyc), 64'(exp_lat));
            end
            if (obs_done) begin
                fin = 1'b1;
                chk("done_busy", 64'(obs_busy), 64'd0);
                chk("done_valid", 64'(obs_valid), 64'd0);
                chk("sb_empty_at_done", 64'(exp_q.size()), 64'd0);
                if (l == 0) begin
                    chk("len0_done_latency", 64'(cyc), 64'(exp_lat));
                    chk("len0_no_valid", 64'(vcnt), 64'd0);
                end else if (pct >= 100) begin
                    chk("valid_cycles", 64'(vcnt), 64'(l));
                    chk("done_after_last", 64'(cyc), 64'(first + l));
                end
            end else begin
                ready = (pct >= 100) ? 1'b1 : ($urandom_range(99, 0) < pct);
                stall = 1'b0;
                if (obs_valid) begin
                    vcnt++;
                    if (ready) pop_cmp("word");
                    else begin
                        stall = 1'b1;
                        pd    = obs_data;
                    end
                end
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=no_done expected=done within 5000 cycles");
        end else begin
            @(negedge clk);
            chk("done_one_cycle", 64'(obs_done), 64'd0);
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{1, 80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 16, 100, 145};
        tbl[1] = '{1, 80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 32, 50, 145};
        tbl[2] = '{1, 80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 0, 100, 145};
        tbl[3] = '{2, 80'hA5A5_5A5A_0F0F_F0F0_1234, 80'h1111_2222_3333_4444_5555, 15, 100, 145};
        tbl[4] = '{0, 80'h0, 80'h0, 64, 100, 1153};
        tbl[5] = '{1, 80'hDEADBEEFCAFEF00D1357, 80'h2468ACE013579BDF0001, 3, 70, 145};

        reset   = 1'b1;
        start_v = '0;
        key     = '0;
        iv      = '0;
        len     = '0;
        ready   = 1'b0;
        sel     = 0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_busy", 64'(obs_busy), 64'd0);
            chk("reset_valid", 64'(obs_valid), 64'd0);
            chk("reset_done", 64'(obs_done), 64'd0);
            chk("reset_data", 64'(obs_data), 64'd0);
        end
        reset = 1'b0;

        for (int t = 0; t < 6; t++) begin
            sel = tbl[t].sel;
            exp_q.delete();
            start_run(tbl[t].key, tbl[t].iv, tbl[t].len);
            monitor(tbl[t].len, tbl[t].pct, tbl[t].exp_lat, 1'b0);
        end

        // Reset in the middle of streaming, then rerun the same vector
        sel = 1;
        ready = 1'b1;
        exp_q.delete();
        start_run(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 16);
        n = 0;
        for (int c = 0; c < 400 && n < 5; c++) begin
            @(negedge clk);
            start_v = '0;
            if (obs_valid) begin
                pop_cmp("pre_reset_word");
                n++;
            end
        end
        chk("pre_reset_words", 64'(n), 64'd5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", 64'(obs_busy), 64'd0);
        chk("midreset_valid", 64'(obs_valid), 64'd0);
        chk("midreset_done", 64'(obs_done), 64'd0);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_reset_no_done", 64'(obs_done), 64'd0);
        end
        exp_q.delete();
        start_run(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 16);
        monitor(16, 100, 145, 1'b0);

        // Start held high: one run, restart only after done
        exp_q.delete();
        start_run(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 16);
        monitor(16, 100, 145, 1'b1);
        chk("hold_idle_busy", 64'(obs_busy), 64'd0);
        @(negedge clk);
        chk("hold_restart_busy", 64'(obs_busy), 64'd1);
        start_v = '0;
        model_push(80'h0123456789ABCDEF0123, 80'hFEDCBA98765432100000, 16, 8);
        monitor(16, 100, 144, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
